generador_ventana: RTL and testbench

GENERADOR_VENTANA -- requirements
Module: generador_ventana

---
 rtl/generador_ventana.sv | 145 ++++++++++++++
 tb/tb_generador_ventana.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/generador_ventana.sv
// generador_ventana: builds a 3x3 cross window (up, left, centre, right, down)
// for every pixel of a raster-order frame with zero padding at the borders.
//
// A delay line holds the last 2*ANCHO accepted samples. Together with the
// sample being transferred, that covers raster indices k-ANCHO..k+ANCHO
// around centre k. The window is registered on the edge that transfers
// index k+ANCHO. After the last pixel of a frame, the block stops accepting
// input and shifts in ANCHO zeros. This flushes the windows of the last line.
//
// Parameters:
//   ANCHO     image width in pixels (2..1023)
//   ALTO      image height in lines (2..1023)
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   valid_in  pixel_in carries a pixel this cycle
//   pixel_in  8-bit pixel, raster order
//   ready_out block accepts a pixel this cycle (low while flushing)
//   A..E      up, left, centre, right, down samples of the window
//   valid_out A..E hold a new window this cycle
//   fin_frame pulses with the window of the last centre of the frame
module generador_ventana #(
    parameter int ANCHO = 64,
    parameter int ALTO  = 48
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic [7:0] pixel_in,
    output logic       ready_out,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [7:0] C,
    output logic [7:0] D,
    output logic [7:0] E,
    output logic       valid_out,
    output logic       fin_frame
);

    localparam int CW  = (ANCHO > 1) ? $clog2(ANCHO) : 1;
    localparam int RW  = (ALTO > 1) ? $clog2(ALTO) : 1;
    localparam int LEN = 2 * ANCHO;

    typedef enum logic [1:0] {LLENADO, PROCESO, VACIADO} estado_t;

    estado_t        estado, estado_sig;
    logic [7:0]     linea [LEN];      // linea[0] is the newest sample
    logic [CW-1:0]  cnt_llenado;
    logic [CW-1:0]  col;              // column of the next centre to emit
    logic [RW-1:0]  fila;             // line of the next centre to emit
    logic           transfer;
    logic           desplazar;
    logic           emitir;
    logic [7:0]     entrada;
    logic           ultima_col;
    logic           ultima_fila;
    logic           penultima_fila;

    assign ready_out      = (estado != VACIADO);
    assign transfer       = valid_in & ready_out;
    assign ultima_col     = (col == CW'(ANCHO - 1));
    assign ultima_fila    = (fila == RW'(ALTO - 1));
    assign penultima_fila = (fila == RW'(ALTO - 2));

    always_comb begin
        estado_sig = estado;
        desplazar  = 1'b0;
        emitir     = 1'b0;
        entrada    = pixel_in;
        case (estado)
            LLENADO: begin
                if (transfer) begin
                    desplazar = 1'b1;
                    if (cnt_llenado == CW'(ANCHO - 1))
                        estado_sig = PROCESO;
                end
            end
            PROCESO: begin
                if (transfer) begin
                    desplazar = 1'b1;
                    emitir    = 1'b1;
                    // The centre one line before the end pairs with the last input index.
                    if (penultima_fila && ultima_col)
                        estado_sig = VACIADO;
                end
            end
            VACIADO: begin
                desplazar = 1'b1;
                emitir    = 1'b1;
                entrada   = 8'd0;
                if (ultima_col)
                    estado_sig = LLENADO;
            end
            default: estado_sig = LLENADO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado      <= LLENADO;
            cnt_llenado <= '0;
            col         <= '0;
            fila        <= '0;
            valid_out   <= 1'b0;
            fin_frame   <= 1'b0;
            A           <= '0;
            B           <= '0;
            C           <= '0;
            D           <= '0;
            E           <= '0;
            for (int i = 0; i < LEN; i++)
                linea[i] <= '0;
        end else begin
            estado    <= estado_sig;
            valid_out <= emitir;
            fin_frame <= emitir && ultima_fila && ultima_col;

            if (desplazar) begin
                linea[0] <= entrada;
                for (int i = 1; i < LEN; i++)
                    linea[i] <= linea[i-1];
            end

            if (estado == LLENADO && desplazar)
                cnt_llenado <= (cnt_llenado == CW'(ANCHO - 1)) ? '0 : cnt_llenado + CW'(1);

            // Before the shift, linea[i] holds index (incoming - 1 - i).
            // The centre is incoming - ANCHO.
            if (emitir) begin
                A <= (fila == '0)  ? 8'd0 : linea[LEN-1];
                B <= (col == '0)   ? 8'd0 : linea[ANCHO];
                C <= linea[ANCHO-1];
                D <= ultima_col    ? 8'd0 : linea[ANCHO-2];
                E <= ultima_fila   ? 8'd0 : entrada;
                if (ultima_col) begin
                    col  <= '0;
                    fila <= ultima_fila ? '0 : fila + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_generador_ventana.sv
module tb_generador_ventana;

    localparam int ANCHO = 4;
    localparam int ALTO  = 3;
    localparam int N     = ANCHO * ALTO;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] pixel_in = 8'd0;
    logic       ready_out;
    logic [7:0] A, B, C, D, E;
    logic       valid_out, fin_frame;

    generador_ventana #(.ANCHO(ANCHO), .ALTO(ALTO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pixel_in(pixel_in),
        .ready_out(ready_out), .A(A), .B(B), .C(C), .D(D), .E(E),
        .valid_out(valid_out), .fin_frame(fin_frame)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the frame as a flat array plus transfer/flush bookkeeping.
    logic [7:0] fr [N];
    int         t = 0;       // transfers accepted in the current frame
    int         drain = 0;   // flush windows still owed
    logic [7:0] last_w [5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] px(input int k);
        return fr[k];
    endfunction

    task automatic model_reset();
        t = 0;
        drain = 0;
        for (int i = 0; i < 5; i++) last_w[i] = 8'd0;
    endtask

    // One clock cycle: drive, advance the model, check the registered result.
    task automatic step(input logic v, input logic [7:0] p);
        int ew;
        int r, c;
        valid_in = v;
        pixel_in = p;
        chk("ready_before", int'(ready_out), int'(drain == 0));
        ew = -1;
        if (drain > 0) begin
            ew = N - drain;
            drain--;
            if (drain == 0) t = 0;
        end else if (v) begin
            fr[t] = p;
            if (t >= ANCHO) ew = t - ANCHO;
            t++;
            if (t == N) drain = ANCHO;
        end
        @(posedge clk);
        #1;
        if (ew >= 0) begin
            r = ew / ANCHO;
            c = ew % ANCHO;
            last_w[0] = (r == 0)         ? 8'd0 : px(ew - ANCHO);
            last_w[1] = (c == 0)         ? 8'd0 : px(ew - 1);
            last_w[2] = px(ew);
            last_w[3] = (c == ANCHO - 1) ? 8'd0 : px(ew + 1);
            last_w[4] = (r == ALTO - 1)  ? 8'd0 : px(ew + ANCHO);
        end
        chk("valid_out", int'(valid_out), int'(ew >= 0));
        chk("fin_frame", int'(fin_frame), int'(ew == N - 1));
        chk("A", int'(A), int'(last_w[0]));
        chk("B", int'(B), int'(last_w[1]));
        chk("C", int'(C), int'(last_w[2]));
        chk("D", int'(D), int'(last_w[3]));
        chk("E", int'(E), int'(last_w[4]));
        chk("ready_after", int'(ready_out), int'(drain == 0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_fin", int'(fin_frame), 0);
        chk("rst_ready", int'(ready_out), 1);
        chk("rst_win", int'({A, B, C, D, E}), 0);
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] p;
        logic       ev;
        logic [7:0] a, b, c, d, e;
        logic       fin;
        logic       rdy;
    } vec_t;

    vec_t tab [20];

    initial begin
        int n;
        // Directed frame for the 4x3 image, with pixel value = index + 1.
        // There is an idle gap after pixel 7, then a 4-cycle flush.
        // Pixel 99 is offered during the flush and must be ignored.
        tab[0]  = '{1, 1,  0, 0, 0, 0, 0, 0, 0, 1};
        tab[1]  = '{1, 2,  0, 0, 0, 0, 0, 0, 0, 1};
        tab[2]  = '{1, 3,  0, 0, 0, 0, 0, 0, 0, 1};
        tab[3]  = '{1, 4,  0, 0, 0, 0, 0, 0, 0, 1};
        tab[4]  = '{1, 5,  1, 0, 0, 1, 2, 5, 0, 1};
        tab[5]  = '{1, 6,  1, 0, 1, 2, 3, 6, 0, 1};
        tab[6]  = '{1, 7,  1, 0, 2, 3, 4, 7, 0, 1};
        tab[7]  = '{0, 0,  0, 0, 2, 3, 4, 7, 0, 1};
        tab[8]  = '{0, 0,  0, 0, 2, 3, 4, 7, 0, 1};
        tab[9]  = '{0, 0,  0, 0, 2, 3, 4, 7, 0, 1};
        tab[10] = '{1, 8,  1, 0, 3, 4, 0, 8, 0, 1};
        tab[11] = '{1, 9,  1, 1, 0, 5, 6, 9, 0, 1};
        tab[12] = '{1, 10, 1, 2, 5, 6, 7, 10, 0, 1};
        tab[13] = '{1, 11, 1, 3, 6, 7, 8, 11, 0, 1};
        tab[14] = '{1, 12, 1, 4, 7, 8, 0, 12, 0, 0};
        tab[15] = '{1, 99, 1, 5, 0, 9, 10, 0, 0, 0};
        tab[16] = '{0, 0,  1, 6, 9, 10, 11, 0, 0, 0};
        tab[17] = '{0, 0,  1, 7, 10, 11, 12, 0, 0, 0};
        tab[18] = '{0, 0,  1, 8, 11, 12, 0, 0, 1, 1};
        tab[19] = '{0, 0,  0, 8, 11, 12, 0, 0, 0, 1};

        model_reset();
        do_reset();

        for (int i = 0; i < 20; i++) begin
            step(tab[i].v, tab[i].p);
            chk($sformatf("tab%0d_valid", i), int'(valid_out), int'(tab[i].ev));
            chk($sformatf("tab%0d_win", i), int'({A, B, C, D, E}),
                int'({tab[i].a, tab[i].b, tab[i].c, tab[i].d, tab[i].e}));
            chk($sformatf("tab%0d_fin", i), int'(fin_frame), int'(tab[i].fin));
            chk($sformatf("tab%0d_rdy", i), int'(ready_out), int'(tab[i].rdy));
        end

        // Reset after six transfers; the new frame must start from (0,0).
        for (int i = 0; i < 6; i++) step(1'b1, 8'(200 + i));
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
        chk("restart_valid", int'(valid_out), 1);
        chk("restart_win", int'({A, B, C, D, E}), int'({8'd0, 8'd0, 8'd1, 8'd2, 8'd5}));

        // Random traffic across several frames.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom));

        // Reset during a flush.
        n = 0;
        while (drain == 0 && n < 200) begin
            step(1'b1, 8'($urandom));
            n++;
        end
        chk("reached_flush", int'(drain > 0), 1);
        step(1'b0, 8'd0);
        do_reset();
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 4) != 0, 8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
